ifid_skid_reg: RTL and testbench

//  IF/ID pipeline boundary register with a 2-entry skid buffer and valid/ready handshake.

---
 rtl/ifid_skid_reg.sv | 100 ++++++++++
 tb/tb_ifid_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// IF/ID boundary register with a two-entry skid buffer.
// ready_o decodes registered state only, so no path from ready_i.
module ifid_skid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic [XLEN-1:0] instrF,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] instrD,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            flush_i
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_n;
  ent_t   m_q, s_q, in_w;
  logic   push, pop;
  logic   ld_m_in, ld_m_s, ld_s;

  assign in_w = '{pc: PCF, pc4: PCPlus4F, instr: instrF};
  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state_n = HALF;
        HALF: begin
          if (push && !pop)      state_n = FULL;
          else if (!push && pop) state_n = EMPTY;
        end
        FULL:  if (pop) state_n = HALF;
        default: state_n = EMPTY;
      endcase
    end
  end

  always_comb begin
    ready_o = (state != FULL);
    valid_o = (state != EMPTY);
    ld_m_in = 1'b0;
    ld_m_s  = 1'b0;
    ld_s    = 1'b0;
    if (!flush_i) begin
      unique case (state)
        EMPTY: ld_m_in = push;
        HALF: begin
          ld_m_in = push & pop;
          ld_s    = push & ~pop;
        end
        FULL:  ld_m_s = pop;
        default: ld_m_in = 1'b0;
      endcase
    end
  end

  // Entries hold their contents unless explicitly loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '{pc: '0, pc4: '0, instr: NOP_INSTR};
      s_q <= '0;
    end else begin
      if (ld_m_in)     m_q <= in_w;
      else if (ld_m_s) m_q <= s_q;
      if (ld_s)        s_q <= in_w;
    end
  end

  assign PCD      = m_q.pc;
  assign PCPlus4D = m_q.pc4;
  assign instrD   = valid_o ? m_q.instr : NOP_INSTR;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed table, async reset,
// and random traffic against a queue model.
module tb_ifid_skid_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PCPlus4F, instrF;
  logic        valid_i, ready_i, flush_i;
  logic        ready_o, valid_o;
  logic [31:0] PCD, PCPlus4D, instrD;

  ifid_skid_reg dut (
    .clk(clk), .reset(reset),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .instrF(instrF),
    .valid_i(valid_i), .ready_o(ready_o),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .instrD(instrD),
    .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } word_t;

  typedef struct {
    bit          v, r, f;
    logic [31:0] pc;
    bit          ev, er, cp;
    logic [31:0] epc;
  } vec_t;

  word_t q[$];
  word_t sent[$];
  int    idx;
  bit    track;
  int    n_chk, n_fail;
  vec_t  tbl[20];

  function automatic logic [31:0] mk_ins(input logic [31:0] p);
    return {p[19:0], 12'h0b3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit f,
                       input logic [31:0] pc, input logic [31:0] ins);
    valid_i  = v;
    ready_i  = r;
    flush_i  = f;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    instrF   = ins;
  endtask

  // Queue model: capacity 2, ready while not full, flush clears.
  task automatic step();
    bit    rdy, psh, pp;
    word_t w;
    rdy = (q.size() < 2);
    psh = valid_i && rdy;
    pp  = (q.size() > 0) && ready_i;
    w   = '{PCF, PCPlus4F, instrF};
    if (track && valid_o && ready_i) begin
      if (idx < sent.size()) chk("order", PCD, sent[idx].pc);
      else chk("extra pop", PCD, 32'hxxxxxxxx);
      idx++;
    end
    if (flush_i) begin
      q.delete();
    end else begin
      if (pp)  void'(q.pop_front());
      if (psh) begin
        q.push_back(w);
        if (track) sent.push_back(w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, q.size() > 0});
    chk({tag, " ready"}, {31'd0, ready_o}, {31'd0, q.size() < 2});
    chk({tag, " instr"}, instrD, (q.size() > 0) ? q[0].ins : NOP);
    if (q.size() > 0) begin
      chk({tag, " pc"},  PCD,      q[0].pc);
      chk({tag, " pc4"}, PCPlus4D, q[0].pc4);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    track  = 0;
    idx    = 0;
    tbl[0]  = '{1, 1, 0, 32'h00, 1, 1, 1, 32'h00};
    tbl[1]  = '{1, 1, 0, 32'h04, 1, 1, 1, 32'h04};
    tbl[2]  = '{1, 1, 0, 32'h08, 1, 1, 1, 32'h08};
    tbl[3]  = '{0, 1, 0, 32'h00, 0, 1, 1, 32'h08};
    tbl[4]  = '{1, 0, 0, 32'h10, 1, 1, 1, 32'h10};
    tbl[5]  = '{1, 0, 0, 32'h14, 1, 0, 1, 32'h10};
    tbl[6]  = '{1, 0, 0, 32'h18, 1, 0, 1, 32'h10};
    tbl[7]  = '{0, 0, 0, 32'h00, 1, 0, 1, 32'h10};
    tbl[8]  = '{0, 1, 0, 32'h00, 1, 1, 1, 32'h14};
    tbl[9]  = '{0, 1, 0, 32'h00, 0, 1, 1, 32'h14};
    tbl[10] = '{1, 0, 0, 32'h20, 1, 1, 1, 32'h20};
    tbl[11] = '{1, 0, 0, 32'h24, 1, 0, 1, 32'h20};
    tbl[12] = '{1, 0, 1, 32'h28, 0, 1, 0, 32'h00};
    tbl[13] = '{0, 1, 0, 32'h00, 0, 1, 0, 32'h00};
    tbl[14] = '{1, 0, 0, 32'h30, 1, 1, 1, 32'h30};
    tbl[15] = '{1, 1, 1, 32'h34, 0, 1, 0, 32'h00};
    tbl[16] = '{0, 1, 0, 32'h00, 0, 1, 0, 32'h00};
    tbl[17] = '{1, 0, 0, 32'h40, 1, 1, 1, 32'h40};
    tbl[18] = '{0, 1, 0, 32'h00, 0, 1, 1, 32'h40};
    tbl[19] = '{0, 1, 0, 32'h00, 0, 1, 1, 32'h40};

    reset = 1'b1;
    drive(1, 1, 0, 32'h0, mk_ins(32'h0));
    #12;
    chk("rst valid", {31'd0, valid_o}, 32'd0);
    chk("rst ready", {31'd0, ready_o}, 32'd1);
    chk("rst instr", instrD, NOP);
    chk("rst pc",    PCD, 32'd0);
    chk("rst pc4",   PCPlus4D, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cyc0 valid", {31'd0, valid_o}, 32'd0);
    chk("cyc0 instr", instrD, NOP);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].pc, mk_ins(tbl[i].pc));
      step();
      chk($sformatf("vec%0d valid", i), {31'd0, valid_o}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d ready", i), {31'd0, ready_o}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d instr", i), instrD,
          tbl[i].ev ? mk_ins(tbl[i].epc) : NOP);
      if (tbl[i].cp) begin
        chk($sformatf("vec%0d pc", i),  PCD, tbl[i].epc);
        chk($sformatf("vec%0d pc4", i), PCPlus4D, tbl[i].epc + 32'd4);
      end
    end

    drive(1, 0, 0, 32'h50, mk_ins(32'h50));
    step();
    drive(1, 0, 0, 32'h54, mk_ins(32'h54));
    step();
    cmp_model("full");
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst valid", {31'd0, valid_o}, 32'd0);
    chk("arst ready", {31'd0, ready_o}, 32'd1);
    chk("arst instr", instrD, NOP);
    chk("arst pc",    PCD, 32'd0);
    #1;
    reset = 1'b0;
    drive(0, 1, 0, 32'h0, 32'h0);
    step();
    cmp_model("post arst");

    track = 1;
    sent.delete();
    idx = 0;
    begin
      logic [31:0] p;
      p = $urandom & 32'hffff_fffc;
      drive(1, 1, 0, p, $urandom);
      step();
      cmp_model("rnd fill");
      for (int c = 0; c < 2000 && sent.size() < 101; c++) begin
        p = $urandom & 32'hffff_fffc;
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              0, p, $urandom);
        step();
        cmp_model("rnd");
      end
    end
    chk("rnd pushed", sent.size(), 32'd101);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 32'h0, 32'h0);
      step();
      cmp_model("drain");
    end
    chk("drain count", idx, sent.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
